// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_bus_arbiter
// Brief  : Round-robin arbiter sharing one RAM port between NREQ requesters,
//          one transaction in flight, with RAM-error and watchdog reporting.
// Rev    : 1.0  initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [NREQ-1:0]      req_ren,
    input  logic [NREQ-1:0]      req_wen,
    input  logic [NREQ*32-1:0]   req_addr,
    input  logic [NREQ*32-1:0]   req_store,
    output logic [NREQ-1:0]      req_wait,
    output logic [31:0]          req_load,
    output logic                 ram_ren,
    output logic                 ram_wen,
    output logic [31:0]          ram_addr,
    output logic [31:0]          ram_store,
    input  logic [31:0]          ram_load,
    input  logic [1:0]           ram_state,
    output logic                 bus_err,
    output logic [2:0]           bus_err_id
);

    localparam int          c_PW         = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [0:0]  c_ST_IDLE    = 1'b0;
    localparam logic [0:0]  c_ST_BUSY    = 1'b1;
    localparam logic [1:0]  c_RAM_ACCESS = 2'd2;
    localparam logic [1:0]  c_RAM_ERROR  = 2'd3;
    localparam logic [31:0] c_WDOG_LAST  = 32'(TIMEOUT - 1);

    logic [0:0]      r_state,      w_state_nxt;
    logic [c_PW-1:0] r_rr_ptr,     w_rr_nxt;
    logic [c_PW-1:0] r_gnt,        w_gnt_nxt;
    logic            r_op,         w_op_nxt;
    logic [31:0]     r_addr,       w_addr_nxt;
    logic [31:0]     r_data,       w_data_nxt;
    logic [31:0]     r_wdog,       w_wdog_nxt;
    logic            r_bus_err,    w_err_nxt;
    logic [2:0]      r_bus_err_id, w_err_id_nxt;

    logic [31:0]     w_addr_arr  [NREQ];
    logic [31:0]     w_store_arr [NREQ];
    logic [NREQ-1:0] w_active;
    logic [NREQ-1:0] w_gnt_oh;
    logic [c_PW-1:0] w_win;
    logic            w_any;
    logic            w_busy;
    logic            w_acc;
    logic            w_tmo;
    logic            w_end;
    logic            w_done;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_addr_arr[gi]  = req_addr[32*gi +: 32];
            assign w_store_arr[gi] = req_store[32*gi +: 32];
        end
    endgenerate

    assign w_active = req_ren | req_wen;

    // Scan downwards so the first active index at or after r_rr_ptr is the last one written.
    always_comb begin
        w_any = |w_active;
        w_win = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_active[(int'(r_rr_ptr) + k) % NREQ]) begin
                w_win = c_PW'((int'(r_rr_ptr) + k) % NREQ);
            end
        end
    end

    assign w_busy = (r_state == c_ST_BUSY);
    assign w_acc  = (ram_state == c_RAM_ACCESS);
    assign w_tmo  = (TIMEOUT != 0) && (r_wdog == c_WDOG_LAST);
    assign w_end  = w_busy && (w_acc || (ram_state == c_RAM_ERROR) || w_tmo);
    // A reset edge coinciding with completion drops the transaction instead of finishing it.
    assign w_done = w_end && nRST;

    always_comb begin
        w_gnt_oh        = '0;
        w_gnt_oh[r_gnt] = w_done;
    end

    assign req_wait   = w_active & ~w_gnt_oh;
    assign req_load   = ram_load;
    assign ram_ren    = w_busy && !r_op;
    assign ram_wen    = w_busy && r_op;
    assign ram_addr   = r_addr;
    assign ram_store  = r_data;
    assign bus_err    = r_bus_err;
    assign bus_err_id = r_bus_err_id;

    always_comb begin
        w_state_nxt  = r_state;
        w_rr_nxt     = r_rr_ptr;
        w_gnt_nxt    = r_gnt;
        w_op_nxt     = r_op;
        w_addr_nxt   = r_addr;
        w_data_nxt   = r_data;
        w_wdog_nxt   = r_wdog;
        w_err_nxt    = 1'b0;
        w_err_id_nxt = r_bus_err_id;
        case (r_state)
            c_ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = c_ST_BUSY;
                    w_gnt_nxt   = w_win;
                    w_op_nxt    = req_wen[w_win];
                    w_addr_nxt  = w_addr_arr[w_win];
                    w_data_nxt  = w_store_arr[w_win];
                    w_wdog_nxt  = '0;
                end
            end
            c_ST_BUSY: begin
                w_wdog_nxt = r_wdog + 32'd1;
                if (w_end) begin
                    w_state_nxt = c_ST_IDLE;
                    w_rr_nxt    = (r_gnt == c_PW'(NREQ - 1)) ? '0 : r_gnt + 1'b1;
                    if (!w_acc) begin
                        w_err_nxt    = 1'b1;
                        w_err_id_nxt = 3'(r_gnt);
                    end
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state      <= c_ST_IDLE;
            r_rr_ptr     <= '0;
            r_gnt        <= '0;
            r_op         <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_wdog       <= '0;
            r_bus_err    <= 1'b0;
            r_bus_err_id <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rr_ptr     <= w_rr_nxt;
            r_gnt        <= w_gnt_nxt;
            r_op         <= w_op_nxt;
            r_addr       <= w_addr_nxt;
            r_data       <= w_data_nxt;
            r_wdog       <= w_wdog_nxt;
            r_bus_err    <= w_err_nxt;
            r_bus_err_id <= w_err_id_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_bus_arbiter
// Brief  : Directed scoreboard bench for mem_bus_arbiter (watchdog and
//          no-watchdog instances share all stimulus).
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam logic [1:0] c_FREE   = 2'd0;
    localparam logic [1:0] c_BUSY   = 2'd1;
    localparam logic [1:0] c_ACCESS = 2'd2;
    localparam logic [1:0] c_ERROR  = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [1:0]  req_ren, req_wen;
    logic [63:0] req_addr, req_store;
    logic [31:0] ram_load;
    logic [1:0]  ram_state;

    logic [1:0]  a_req_wait, b_req_wait;
    logic [31:0] a_req_load, b_req_load;
    logic        a_ram_ren, b_ram_ren, a_ram_wen, b_ram_wen;
    logic [31:0] a_ram_addr, b_ram_addr, a_ram_store, b_ram_store;
    logic        a_bus_err, b_bus_err;
    logic [2:0]  a_bus_err_id, b_bus_err_id;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  id;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] load;
        logic        err;
    } exp_t;
    exp_t sb[$];

    always #5 CLK = ~CLK;

    mem_bus_arbiter #(.NREQ(2), .TIMEOUT(4)) u_dut_a (
        .CLK(CLK), .nRST(nRST), .req_ren(req_ren), .req_wen(req_wen),
        .req_addr(req_addr), .req_store(req_store), .req_wait(a_req_wait),
        .req_load(a_req_load), .ram_ren(a_ram_ren), .ram_wen(a_ram_wen),
        .ram_addr(a_ram_addr), .ram_store(a_ram_store), .ram_load(ram_load),
        .ram_state(ram_state), .bus_err(a_bus_err), .bus_err_id(a_bus_err_id)
    );

    mem_bus_arbiter #(.NREQ(2), .TIMEOUT(0)) u_dut_b (
        .CLK(CLK), .nRST(nRST), .req_ren(req_ren), .req_wen(req_wen),
        .req_addr(req_addr), .req_store(req_store), .req_wait(b_req_wait),
        .req_load(b_req_load), .ram_ren(b_ram_ren), .ram_wen(b_ram_wen),
        .ram_addr(b_ram_addr), .ram_store(b_ram_store), .ram_load(ram_load),
        .ram_state(ram_state), .bus_err(b_bus_err), .bus_err_id(b_bus_err_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic set_req(input int i, input logic [31:0] addr, input logic [31:0] store);
        req_addr[32*i +: 32]  = addr;
        req_store[32*i +: 32] = store;
    endtask

    task automatic push_exp(input logic [1:0] id, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] load, input logic err);
        exp_t e;
        e.id = id; e.wr = wr; e.addr = addr; e.data = data; e.load = load; e.err = err;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        nRST = 1'b0; req_ren = '0; req_wen = '0; ram_state = c_FREE;
        next_cycle();
        next_cycle();
        nRST = 1'b1;
    endtask

    // A requester whose wait drops while the RAM strobe is up has finished its transaction.
    always @(negedge CLK) begin
        exp_t e;
        if (nRST && (a_ram_ren || a_ram_wen)) begin
            for (int i = 0; i < 2; i++) begin
                if ((req_ren[i] || req_wen[i]) && !a_req_wait[i]) begin
                    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("sb_id", 32'(i), 32'(e.id));
                        chk("sb_op_wen", 32'(a_ram_wen), 32'(e.wr));
                        chk("sb_addr", a_ram_addr, e.addr);
                        if (e.wr) chk("sb_store", a_ram_store, e.data);
                        if (!e.wr && !e.err) chk("sb_load", a_req_load, e.load);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        nRST = 1'b0; req_ren = '0; req_wen = '0; req_addr = '0; req_store = '0;
        ram_load = '0; ram_state = c_FREE;
        next_cycle();
        next_cycle();
        sample();
        chk("rst_ram_ren", 32'(a_ram_ren), 32'd0);
        chk("rst_ram_wen", 32'(a_ram_wen), 32'd0);
        chk("rst_ram_addr", a_ram_addr, 32'd0);
        chk("rst_ram_store", a_ram_store, 32'd0);
        chk("rst_bus_err", 32'(a_bus_err), 32'd0);
        chk("rst_bus_err_id", 32'(a_bus_err_id), 32'd0);
        chk("rst_req_wait", 32'(a_req_wait), 32'd0);
        next_cycle();
        nRST = 1'b1;

        // single read, ACCESS on the third strobe cycle
        req_ren = 2'b01; set_req(0, 32'h40, 32'h0);
        push_exp(2'd0, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0);
        sample();
        chk("t1_c0_ren", 32'(a_ram_ren), 32'd0);
        chk("t1_c0_wait", 32'(a_req_wait), 32'b01);
        next_cycle(); ram_state = c_BUSY;
        sample();
        chk("t1_c1_ren", 32'(a_ram_ren), 32'd1);
        chk("t1_c1_addr", a_ram_addr, 32'h40);
        chk("t1_c1_wait", 32'(a_req_wait), 32'b01);
        next_cycle();
        sample();
        chk("t1_c2_ren", 32'(a_ram_ren), 32'd1);
        next_cycle(); ram_state = c_ACCESS; ram_load = 32'hDEADBEEF;
        sample();
        chk("t1_c3_wait", 32'(a_req_wait), 32'b00);
        chk("t1_c3_load", a_req_load, 32'hDEADBEEF);
        next_cycle(); ram_state = c_FREE; req_ren = '0;
        sample();
        chk("t1_c4_ren", 32'(a_ram_ren), 32'd0);

        // two continuous readers alternate
        do_reset();
        req_ren = 2'b11; set_req(0, 32'h100, 32'h0); set_req(1, 32'h200, 32'h0);
        for (int k = 0; k < 4; k++) begin
            push_exp(2'(k % 2), 1'b0, (k % 2 == 0) ? 32'h100 : 32'h200, 32'h0,
                     32'hA0000000 + 32'(k), 1'b0);
            ram_state = c_FREE;
            sample();
            chk("t2_idle_ren", 32'(a_ram_ren), 32'd0);
            chk("t2_idle_wait", 32'(a_req_wait), 32'b11);
            next_cycle();
            sample();
            chk("t2_busy_addr", a_ram_addr, (k % 2 == 0) ? 32'h100 : 32'h200);
            next_cycle(); ram_state = c_ACCESS; ram_load = 32'hA0000000 + 32'(k);
            sample();
            chk("t2_done_wait", 32'(a_req_wait), (k % 2 == 0) ? 32'b10 : 32'b01);
            next_cycle();
        end
        req_ren = '0; ram_state = c_FREE;
        sample();
        chk("t2_end_ren", 32'(a_ram_ren), 32'd0);
        next_cycle();

        // write wins over read on the same requester
        req_ren = 2'b10; req_wen = 2'b10;
        set_req(0, 32'h999, 32'hFFFF); set_req(1, 32'h80, 32'h1234);
        push_exp(2'd1, 1'b1, 32'h80, 32'h1234, 32'h0, 1'b0);
        sample();
        chk("t3_c0_wen", 32'(a_ram_wen), 32'd0);
        next_cycle(); ram_state = c_ACCESS;
        sample();
        chk("t3_wen", 32'(a_ram_wen), 32'd1);
        chk("t3_ren", 32'(a_ram_ren), 32'd0);
        chk("t3_store", a_ram_store, 32'h1234);
        chk("t3_addr", a_ram_addr, 32'h80);
        chk("t3_wait", 32'(a_req_wait), 32'b00);
        next_cycle(); req_ren = '0; req_wen = '0; ram_state = c_FREE;
        sample();
        chk("t3_end_wen", 32'(a_ram_wen), 32'd0);
        next_cycle();

        // RAM error on requester 1
        req_ren = 2'b10; set_req(1, 32'h300, 32'h0);
        push_exp(2'd1, 1'b0, 32'h300, 32'h0, 32'h0, 1'b1);
        sample();
        next_cycle(); ram_state = c_BUSY;
        sample();
        chk("t4_ren", 32'(a_ram_ren), 32'd1);
        next_cycle(); ram_state = c_ERROR;
        sample();
        chk("t4_wait", 32'(a_req_wait), 32'b00);
        chk("t4_err_early", 32'(a_bus_err), 32'd0);
        next_cycle(); req_ren = '0; ram_state = c_FREE;
        sample();
        chk("t4_err", 32'(a_bus_err), 32'd1);
        chk("t4_err_id", 32'(a_bus_err_id), 32'd1);
        chk("t4_idle_ren", 32'(a_ram_ren), 32'd0);
        next_cycle();
        sample();
        chk("t4_err_pulse", 32'(a_bus_err), 32'd0);
        chk("t4_err_id_hold", 32'(a_bus_err_id), 32'd1);
        next_cycle();

        // watchdog: RAM stuck BUSY; the TIMEOUT=0 instance keeps waiting
        req_ren = 2'b01; set_req(0, 32'h500, 32'h0);
        push_exp(2'd0, 1'b0, 32'h500, 32'h0, 32'h0, 1'b1);
        sample();
        for (int b = 1; b <= 4; b++) begin
            next_cycle(); ram_state = c_BUSY;
            sample();
            chk("t5_ren", 32'(a_ram_ren), 32'd1);
            chk("t5_wait", 32'(a_req_wait), (b == 4) ? 32'b00 : 32'b01);
            chk("t5_nowdog_wait", 32'(b_req_wait), 32'b01);
        end
        next_cycle(); req_ren = '0;
        sample();
        chk("t5_err", 32'(a_bus_err), 32'd1);
        chk("t5_err_id", 32'(a_bus_err_id), 32'd0);
        chk("t5_idle_ren", 32'(a_ram_ren), 32'd0);
        chk("t5_nowdog_err", 32'(b_bus_err), 32'd0);
        for (int n = 0; n < 20; n++) next_cycle();
        sample();
        chk("t5_nowdog_ren", 32'(b_ram_ren), 32'd1);
        chk("t5_nowdog_addr", b_ram_addr, 32'h500);
        next_cycle();

        // ACCESS on the timeout cycle completes cleanly
        do_reset();
        req_ren = 2'b01; set_req(0, 32'h540, 32'h0); ram_load = 32'h55AA55AA;
        push_exp(2'd0, 1'b0, 32'h540, 32'h0, 32'h55AA55AA, 1'b0);
        sample();
        for (int b = 1; b <= 4; b++) begin
            next_cycle(); ram_state = (b == 4) ? c_ACCESS : c_BUSY;
            sample();
            chk("t5b_wait", 32'(a_req_wait), (b == 4) ? 32'b00 : 32'b01);
        end
        next_cycle(); req_ren = '0; ram_state = c_FREE;
        sample();
        chk("t5b_no_err", 32'(a_bus_err), 32'd0);
        next_cycle();

        // reset during BUSY together with ACCESS; pointer returns to 0
        req_ren = 2'b11; set_req(0, 32'h600, 32'h0); set_req(1, 32'h700, 32'h0);
        sample();
        next_cycle(); ram_state = c_BUSY;
        sample();
        chk("t6_grant1_addr", a_ram_addr, 32'h700);
        next_cycle(); nRST = 1'b0; ram_state = c_ACCESS;
        sample();
        chk("t6_rst_wait", 32'(a_req_wait), 32'b11);
        next_cycle(); nRST = 1'b1; ram_state = c_FREE;
        push_exp(2'd0, 1'b0, 32'h600, 32'h0, 32'h0BADF00D, 1'b0);
        sample();
        chk("t6_rst_ren", 32'(a_ram_ren), 32'd0);
        chk("t6_rst_addr", a_ram_addr, 32'd0);
        chk("t6_idle_wait", 32'(a_req_wait), 32'b11);
        next_cycle(); ram_state = c_ACCESS; ram_load = 32'h0BADF00D;
        sample();
        chk("t6_grant0_addr", a_ram_addr, 32'h600);
        chk("t6_done_wait", 32'(a_req_wait), 32'b10);
        next_cycle(); req_ren = '0; ram_state = c_FREE;
        sample();
        chk("t6_end_ren", 32'(a_ram_ren), 32'd0);
        next_cycle();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
